// File: rtl/pll_reset_sequencer_if.sv
// PLL sequencer bundle: control/lock inputs and registered status outputs.
// The master side (system / PLL wrapper) drives enable and pll_locked; the
// slave side is the sequencer itself. Optional loss_cnt is present only when
// PLL_SEQ_LOSS_COUNT_EN is defined.
interface pll_reset_sequencer_if;
  logic       enable;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_cnt;
`endif

  modport master (
    output enable, pll_locked,
    input  pll_rst, sys_rst_n, ready, fail, retry_cnt, state_o
`ifdef PLL_SEQ_LOSS_COUNT_EN
    , input loss_cnt
`endif
  );

  modport slave (
    input  enable, pll_locked,
    output pll_rst, sys_rst_n, ready, fail, retry_cnt, state_o
`ifdef PLL_SEQ_LOSS_COUNT_EN
    , output loss_cnt
`endif
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and downstream reset release sequencer, refclk domain.
// Optional lock-loss counter output enabled by defining PLL_SEQ_LOSS_COUNT_EN.
//
// state      | meaning
// IDLE       | parked, PLL held in reset, retry count cleared
// ASSERT_RST | PLL reset pulse, RST_PULSE_CYCLES long
// WAIT_LOCK  | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABLE     | lock must hold for LOCK_STABLE_CYCLES consecutive cycles
// RUN        | downstream reset released, ready=1
// FAIL       | retries exhausted, PLL held in reset until enable drops
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_reset_sequencer_if.slave  bus
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT_RST = 3'd1,
    WAIT_LOCK  = 3'd2,
    STABLE     = 3'd3,
    RUN        = 3'd4,
    FAIL       = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          lock_m, lock_s;
  logic [3:0]    retry_q, retry_n, retry_inc;
  logic          pll_rst_q, sys_rst_n_q, ready_q, fail_q;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic          loss_event;
  logic [7:0]    loss_q;
`endif

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= bus.pll_locked;
      lock_s <= lock_m;
    end
  end

  // State register, per-state cycle counter, retry count and Moore outputs
  // decoded from the next state so they change on the entering edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state       <= state_n;
      retry_q     <= retry_n;
      if (state_n != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CW'(1);
      pll_rst_q   <= (state_n == IDLE) || (state_n == ASSERT_RST) || (state_n == FAIL);
      sys_rst_n_q <= (state_n == RUN);
      ready_q     <= (state_n == RUN);
      fail_q      <= (state_n == FAIL);
    end
  end

  // Next-state and retry bookkeeping; enable=0 overrides every transition.
  always_comb begin
    state_n   = state;
    retry_n   = retry_q;
    retry_inc = retry_q + 4'd1;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    loss_event = 1'b0;
`endif
    if (!bus.enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:       state_n = ASSERT_RST;
        ASSERT_RST: if (cnt == RST_LAST) state_n = WAIT_LOCK;
        WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (lock_s) begin
            state_n = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_n = retry_inc;
            if (retry_inc == RETRY_LIMIT) state_n = FAIL;
            else                          state_n = ASSERT_RST;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_n = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_n = RUN;
            retry_n = '0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_n = ASSERT_RST;
`ifdef PLL_SEQ_LOSS_COUNT_EN
            loss_event = 1'b1;
`endif
          end
        end
        FAIL:    state_n = FAIL;
        default: state_n = IDLE;
      endcase
    end
    if (state_n == IDLE) retry_n = '0;
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  // Saturating count of lock losses while running; only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      loss_q <= '0;
    else if (loss_event && (loss_q != 8'hFF))
      loss_q <= loss_q + 8'd1;
  end
  assign bus.loss_cnt = loss_q;
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (default parameters).
// Expected edge times come from a timeline model: each attempt is a 16-cycle
// pulse followed by a 4096-cycle wait window; a pll_locked change made just
// after edge k is acted on by the FSM at edge k+3; RUN follows 64 qualified
// cycles later.
module tb_pll_reset_sequencer;

  localparam int RST_P   = 16;
  localparam int TMO     = 4096;
  localparam int STAB    = 64;
  localparam int ATTEMPT = RST_P + TMO;
  localparam int SEEN    = 3;

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic flush_idle();
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.state_o !== 3'd0) $display("FAIL rst_state: got %0d want 0", bus.state_o); else passed++;
    checks++; if (bus.pll_rst !== 1'b1) $display("FAIL rst_pll_rst: got %b want 1", bus.pll_rst); else passed++;
    checks++; if (bus.sys_rst_n !== 1'b0) $display("FAIL rst_sys_rst_n: got %b want 0", bus.sys_rst_n); else passed++;
    checks++; if (bus.ready !== 1'b0 || bus.fail !== 1'b0) $display("FAIL rst_ready_fail: got %b%b want 00", bus.ready, bus.fail); else passed++;
    checks++; if (bus.retry_cnt !== 4'd0) $display("FAIL rst_retry: got %0d want 0", bus.retry_cnt); else passed++;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.loss_cnt !== 8'd0) $display("FAIL rst_loss_cnt: got %0d want 0", bus.loss_cnt); else passed++;
`endif
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (bus.state_o !== 3'd0 || bus.pll_rst !== 1'b1) $display("FAIL idle_hold: got state %0d pll_rst %b want 0/1", bus.state_o, bus.pll_rst); else passed++;
  endtask

  // Bring-up with f timeouts before lock arrives d cycles into the last window.
  task automatic run_bringup(input int f, input int d, input string tag);
    int   falls[$];
    int   rises[$];
    int   c0, wf, lock_edge, run_edge, ready_edge, sysr_edge, retry_pre, limit;
    logic prev_rst;
    c0         = cyc;
    bus.enable = 1'b1;
    wf         = c0 + 1 + RST_P + f * ATTEMPT;
    lock_edge  = wf + d;
    run_edge   = lock_edge + SEEN + STAB;
    limit      = run_edge + 20;
    prev_rst   = bus.pll_rst;
    ready_edge = -1;
    sysr_edge  = -1;
    retry_pre  = -1;
    while (cyc < limit && ready_edge < 0) begin
      step();
      if (prev_rst && !bus.pll_rst) falls.push_back(cyc);
      if (!prev_rst && bus.pll_rst) rises.push_back(cyc);
      prev_rst = bus.pll_rst;
      if (bus.ready && ready_edge < 0) ready_edge = cyc;
      if (bus.sys_rst_n && sysr_edge < 0) sysr_edge = cyc;
      if (cyc == run_edge - 1) retry_pre = int'(bus.retry_cnt);
      if (cyc == lock_edge) bus.pll_locked = 1'b1;
    end
    checks++; if (falls.size() != f + 1) $display("FAIL %s_pulse_count: got %0d want %0d", tag, falls.size(), f + 1); else passed++;
    for (int a = 0; a <= f; a++) begin
      if (a < falls.size()) begin
        checks++; if (falls[a] != c0 + 1 + RST_P + a * ATTEMPT) $display("FAIL %s_rst_fall%0d: got %0d want %0d", tag, a, falls[a] - c0, 1 + RST_P + a * ATTEMPT); else passed++;
      end
    end
    checks++; if (rises.size() != f) $display("FAIL %s_retry_pulses: got %0d want %0d", tag, rises.size(), f); else passed++;
    for (int a = 0; a < f; a++) begin
      if (a < rises.size()) begin
        checks++; if (rises[a] != c0 + 1 + RST_P + a * ATTEMPT + TMO) $display("FAIL %s_rst_rise%0d: got %0d want %0d", tag, a, rises[a] - c0, 1 + RST_P + a * ATTEMPT + TMO); else passed++;
      end
    end
    checks++; if (ready_edge != run_edge) $display("FAIL %s_ready_time: got %0d want %0d after lock", tag, ready_edge - lock_edge, run_edge - lock_edge); else passed++;
    checks++; if (sysr_edge != run_edge) $display("FAIL %s_sys_rst_n_time: got %0d want %0d after lock", tag, sysr_edge - lock_edge, run_edge - lock_edge); else passed++;
    checks++; if (retry_pre != f) $display("FAIL %s_retry_before_run: got %0d want %0d", tag, retry_pre, f); else passed++;
    step();
    checks++; if (bus.state_o !== 3'd4 || bus.retry_cnt !== 4'd0 || bus.pll_rst !== 1'b0) $display("FAIL %s_run_state: got state %0d retry %0d pll_rst %b want 4/0/0", tag, bus.state_o, bus.retry_cnt, bus.pll_rst); else passed++;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    step();
    checks++; if (bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0 || bus.pll_rst !== 1'b1) $display("FAIL %s_disable: got state %0d sys_rst_n %b pll_rst %b want 0/0/1", tag, bus.state_o, bus.sys_rst_n, bus.pll_rst); else passed++;
    flush_idle();
  endtask

  task automatic test_bringup();
    run_bringup(0, 100, "bringup");
  endtask

  task automatic test_timeout_retries();
    int   falls[$];
    int   rises[$];
    int   steps[$];
    int   c0, fail_edge;
    logic prev_rst;
    logic [3:0] prev_retry;
    c0         = cyc;
    bus.enable = 1'b1;
    fail_edge  = c0 + 1 + RST_P + 2 * ATTEMPT + TMO;
    prev_rst   = bus.pll_rst;
    prev_retry = bus.retry_cnt;
    while (cyc < fail_edge + 30) begin
      step();
      if (prev_rst && !bus.pll_rst) falls.push_back(cyc);
      if (!prev_rst && bus.pll_rst) rises.push_back(cyc);
      if (bus.retry_cnt != prev_retry) steps.push_back(int'(bus.retry_cnt));
      prev_rst   = bus.pll_rst;
      prev_retry = bus.retry_cnt;
      if (cyc == fail_edge - 1) begin
        checks++; if (bus.state_o !== 3'd2 || bus.retry_cnt !== 4'd2) $display("FAIL to_pre_fail: got state %0d retry %0d want 2/2", bus.state_o, bus.retry_cnt); else passed++;
      end
      if (cyc == fail_edge) begin
        checks++; if (bus.state_o !== 3'd5 || bus.fail !== 1'b1) $display("FAIL to_fail_entry: got state %0d fail %b want 5/1", bus.state_o, bus.fail); else passed++;
        checks++; if (bus.retry_cnt !== 4'd3 || bus.pll_rst !== 1'b1) $display("FAIL to_fail_outputs: got retry %0d pll_rst %b want 3/1", bus.retry_cnt, bus.pll_rst); else passed++;
      end
    end
    checks++; if (falls.size() != 3 || rises.size() != 3) $display("FAIL to_pulse_count: got %0d falls %0d rises want 3/3", falls.size(), rises.size()); else passed++;
    for (int a = 0; a < 3; a++) begin
      if (a < falls.size() && a < rises.size()) begin
        checks++; if (falls[a] != c0 + 1 + RST_P + a * ATTEMPT || rises[a] - falls[a] != TMO) $display("FAIL to_window%0d: got fall %0d width %0d want %0d/%0d", a, falls[a] - c0, rises[a] - falls[a], 1 + RST_P + a * ATTEMPT, TMO); else passed++;
      end
    end
    checks++; if (steps.size() != 3) $display("FAIL to_retry_steps: got %0d changes want 3", steps.size()); else passed++;
    for (int a = 0; a < 3; a++) begin
      if (a < steps.size()) begin
        checks++; if (steps[a] != a + 1) $display("FAIL to_retry_step%0d: got %0d want %0d", a, steps[a], a + 1); else passed++;
      end
    end
    checks++; if (bus.fail !== 1'b1 || bus.pll_rst !== 1'b1 || bus.state_o !== 3'd5) $display("FAIL to_fail_hold: got fail %b pll_rst %b state %0d want 1/1/5", bus.fail, bus.pll_rst, bus.state_o); else passed++;
    bus.enable = 1'b0;
    step();
    checks++; if (bus.state_o !== 3'd0 || bus.fail !== 1'b0 || bus.retry_cnt !== 4'd0) $display("FAIL to_disable: got state %0d fail %b retry %0d want 0/0/0", bus.state_o, bus.fail, bus.retry_cnt); else passed++;
    flush_idle();
  endtask

  task automatic test_lock_glitch();
    int c0, lk, drop, back, run_edge, ready_edge, max_retry;
    c0         = cyc;
    bus.enable = 1'b1;
    lk         = c0 + 1 + RST_P + 30;
    drop       = lk + SEEN + 40;
    back       = drop + 3;
    run_edge   = back + SEEN + STAB;
    ready_edge = -1;
    max_retry  = 0;
    while (cyc < run_edge + 10 && ready_edge < 0) begin
      step();
      if (bus.ready && ready_edge < 0) ready_edge = cyc;
      if (int'(bus.retry_cnt) > max_retry) max_retry = int'(bus.retry_cnt);
      if (cyc == drop + 2) begin
        checks++; if (bus.state_o !== 3'd3) $display("FAIL gl_still_stable: got %0d want 3", bus.state_o); else passed++;
      end
      if (cyc == drop + SEEN) begin
        checks++; if (bus.state_o !== 3'd2) $display("FAIL gl_back_to_wait: got %0d want 2", bus.state_o); else passed++;
      end
      if (cyc == lk)   bus.pll_locked = 1'b1;
      if (cyc == drop) bus.pll_locked = 1'b0;
      if (cyc == back) bus.pll_locked = 1'b1;
    end
    checks++; if (ready_edge != run_edge) $display("FAIL gl_ready_time: got %0d want %0d after relock", ready_edge - back, run_edge - back); else passed++;
    checks++; if (max_retry != 0) $display("FAIL gl_retry: got %0d want 0", max_retry); else passed++;
    flush_idle();
  endtask

  task automatic test_run_loss();
    int c0, lk, run_edge, k, lk2, ready_edge;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    int loss_before;
`endif
    c0         = cyc;
    bus.enable = 1'b1;
    lk         = c0 + 1 + RST_P + 5;
    run_edge   = lk + SEEN + STAB;
    while (cyc < run_edge + 5) begin
      step();
      if (cyc == lk) bus.pll_locked = 1'b1;
    end
    checks++; if (bus.ready !== 1'b1) $display("FAIL rl_running: got ready %b want 1", bus.ready); else passed++;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    loss_before = int'(bus.loss_cnt);
`endif
    k = cyc;
    bus.pll_locked = 1'b0;
    step();
    step();
    checks++; if (bus.ready !== 1'b1) $display("FAIL rl_latency: got ready %b want 1 two edges after drop", bus.ready); else passed++;
    step();
    checks++; if (bus.state_o !== 3'd1 || bus.sys_rst_n !== 1'b0 || bus.pll_rst !== 1'b1) $display("FAIL rl_drop: got state %0d sys_rst_n %b pll_rst %b want 1/0/1", bus.state_o, bus.sys_rst_n, bus.pll_rst); else passed++;
    checks++; if (bus.retry_cnt !== 4'd0 || bus.ready !== 1'b0) $display("FAIL rl_retry: got retry %0d ready %b want 0/0", bus.retry_cnt, bus.ready); else passed++;
    lk2        = k + SEEN + RST_P + 10;
    ready_edge = -1;
    while (cyc < lk2 + SEEN + STAB + 10 && ready_edge < 0) begin
      step();
      if (bus.ready && ready_edge < 0) ready_edge = cyc;
      if (cyc == lk2) bus.pll_locked = 1'b1;
    end
    checks++; if (ready_edge != lk2 + SEEN + STAB) $display("FAIL rl_relock_time: got %0d want %0d after lock", ready_edge - lk2, SEEN + STAB); else passed++;
    checks++; if (bus.retry_cnt !== 4'd0) $display("FAIL rl_relock_retry: got %0d want 0", bus.retry_cnt); else passed++;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (int'(bus.loss_cnt) != loss_before + 1) $display("FAIL rl_loss_cnt: got %0d want %0d", bus.loss_cnt, loss_before + 1); else passed++;
`endif
    flush_idle();
  endtask

  task automatic test_async_reset();
    int c, fall_edge;
    bus.enable = 1'b1;
    repeat (1 + RST_P + 20) step();
    checks++; if (bus.state_o !== 3'd2 || bus.pll_rst !== 1'b0) $display("FAIL ar_pre: got state %0d pll_rst %b want 2/0", bus.state_o, bus.pll_rst); else passed++;
    #5 rst_n = 1'b0;
    #1;
    checks++; if (bus.state_o !== 3'd0 || bus.pll_rst !== 1'b1 || bus.sys_rst_n !== 1'b0) $display("FAIL ar_immediate: got state %0d pll_rst %b sys_rst_n %b want 0/1/0", bus.state_o, bus.pll_rst, bus.sys_rst_n); else passed++;
    checks++; if (bus.ready !== 1'b0 || bus.fail !== 1'b0 || bus.retry_cnt !== 4'd0) $display("FAIL ar_status: got ready %b fail %b retry %0d want 0/0/0", bus.ready, bus.fail, bus.retry_cnt); else passed++;
    #2 rst_n = 1'b1;
    c         = cyc;
    fall_edge = -1;
    while (cyc < c + RST_P + 20 && fall_edge < 0) begin
      step();
      if (!bus.pll_rst) fall_edge = cyc;
    end
    checks++; if (fall_edge != c + 1 + RST_P) $display("FAIL ar_full_pulse: got %0d want %0d", fall_edge - c, 1 + RST_P); else passed++;
    flush_idle();
  endtask

  task automatic test_enable_drop_stable();
    int c0, lk, s;
    c0         = cyc;
    bus.enable = 1'b1;
    lk         = c0 + 1 + RST_P + 8;
    s          = lk + SEEN + 10;
    while (cyc < s) begin
      step();
      if (cyc == lk) bus.pll_locked = 1'b1;
    end
    checks++; if (bus.state_o !== 3'd3) $display("FAIL ed_in_stable: got %0d want 3", bus.state_o); else passed++;
    bus.enable = 1'b0;
    step();
    checks++; if (bus.state_o !== 3'd0 || bus.pll_rst !== 1'b1 || bus.sys_rst_n !== 1'b0) $display("FAIL ed_next_edge: got state %0d pll_rst %b sys_rst_n %b want 0/1/0", bus.state_o, bus.pll_rst, bus.sys_rst_n); else passed++;
    flush_idle();
  endtask

  task automatic test_random_bringup();
    int f, d;
    for (int i = 0; i < 3; i++) begin
      f = int'($urandom_range(0, 2));
      d = int'($urandom_range(0, 300));
      run_bringup(f, d, "random");
    end
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    test_reset();
    test_bringup();
    test_timeout_retries();
    test_lock_glitch();
    test_run_loss();
    test_async_reset();
    test_enable_drop_stable();
    test_random_bringup();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
